// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-N packet stream demultiplexer:
// routing FSM encoding and select-width derivation.
package demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } demux_state_e;

  // Width of a channel index; a single-channel select still needs one bit.
  function automatic int sel_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/demux_stream_1ton_if.sv
// Upstream beat + per-channel downstream bundle for demux_stream_1ton.
// master drives upstream beats and downstream ready; slave is the demux.
interface demux_stream_1ton_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  import demux_pkg::*;

  localparam int SEL_W = sel_w(NUM_CH);

  logic [DATA_W-1:0]        d_in;
  logic [SEL_W-1:0]         sel_in;
  logic                     valid_in;
  logic                     last_in;
  logic                     ready_out;
  logic [NUM_CH*DATA_W-1:0] y_out;
  logic [NUM_CH-1:0]        valid_out;
  logic [NUM_CH-1:0]        last_out;
  logic [NUM_CH-1:0]        ready_in;
  logic [CNT_W-1:0]         drop_cnt_out;

  modport master (
    output d_in, sel_in, valid_in, last_in, ready_in,
    input  ready_out, y_out, valid_out, last_out, drop_cnt_out
  );

  modport slave (
    input  d_in, sel_in, valid_in, last_in, ready_in,
    output ready_out, y_out, valid_out, last_out, drop_cnt_out
  );

endinterface

// File: rtl/demux_out_slot.sv
// One-entry output register for a single demux channel.
// A load wins over a same-cycle consume so throughput stays one beat per cycle.
module demux_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              load_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic              last_o,
  output logic [DATA_W-1:0] y_o
);

  logic              vld_q;
  logic              last_q;
  logic [DATA_W-1:0] dat_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      dat_q  <= '0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      last_q <= last_i;
      dat_q  <= d_i;
    end else if (vld_q && ready_i) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      dat_q  <= '0;
    end
  end

  // Idle slots present all-zero payload and last.
  assign valid_o = vld_q;
  assign last_o  = vld_q & last_q;
  assign y_o     = vld_q ? dat_q : '0;

endmodule

// File: rtl/demux_stream_1ton.sv
// Packet-granular 1-to-N stream demux: channel is picked on the first beat,
// locked until last; out-of-range selects discard the packet and are counted.
module demux_stream_1ton
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input logic          clk_in,
  input logic          rst_in,
  demux_stream_1ton_if.slave bus
);

  localparam int SEL_W = sel_w(NUM_CH);
  localparam int NPAD  = 2 ** SEL_W;
  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(NUM_CH);

  demux_state_e      state_q;
  logic [SEL_W-1:0]  lock_q;
  logic [CNT_W-1:0]  drop_q;

  logic [NUM_CH-1:0] vld;
  logic [NUM_CH-1:0] load;
  logic [NPAD-1:0]   vld_pad;
  logic [NPAD-1:0]   rdy_pad;
  logic [SEL_W-1:0]  tgt;
  logic              sel_oob;
  logic              ready_c;
  logic              acc;
  logic              route_acc;
  logic              disc;

  // Padding to a power of two keeps indexing by an out-of-range select defined.
  assign vld_pad = NPAD'(vld);
  assign rdy_pad = NPAD'(bus.ready_in);

  always_comb begin
    sel_oob   = ({1'b0, bus.sel_in} >= NCH);
    tgt       = (state_q == ST_ROUTE) ? lock_q : bus.sel_in;
    ready_c   = 1'b0;
    if (!rst_in) begin
      if (state_q == ST_DROP)                   ready_c = 1'b1;
      else if (state_q == ST_IDLE && sel_oob)   ready_c = 1'b1;
      else                                      ready_c = !vld_pad[tgt] || rdy_pad[tgt];
    end
    acc       = bus.valid_in && ready_c;
    route_acc = acc && (state_q == ST_ROUTE || (state_q == ST_IDLE && !sel_oob));
    disc      = acc && !route_acc;
    load      = '0;
    for (int k = 0; k < NUM_CH; k++)
      load[k] = route_acc && (tgt == SEL_W'(k));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      lock_q  <= '0;
      drop_q  <= '0;
    end else begin
      if (acc) begin
        case (state_q)
          ST_IDLE: begin
            if (!bus.last_in) begin
              if (sel_oob) state_q <= ST_DROP;
              else begin
                state_q <= ST_ROUTE;
                lock_q  <= bus.sel_in;
              end
            end
          end
          ST_ROUTE: if (bus.last_in) state_q <= ST_IDLE;
          ST_DROP:  if (bus.last_in) state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end
      if (disc && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_out_slot #(.DATA_W(DATA_W)) u_slot (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .load_i  (load[k]),
      .d_i     (bus.d_in),
      .last_i  (bus.last_in),
      .ready_i (bus.ready_in[k]),
      .valid_o (vld[k]),
      .last_o  (bus.last_out[k]),
      .y_o     (bus.y_out[k*DATA_W +: DATA_W])
    );
  end

  assign bus.valid_out    = vld;
  assign bus.ready_out    = ready_c;
  assign bus.drop_cnt_out = drop_q;

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Drives one beat stream into three demux configurations (4ch/8b cnt,
// 3ch/8b cnt, 3ch/2b cnt) and compares each against a packet-level model.
module tb_demux_stream_1ton;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v = 1'b0;
  logic [7:0] d = '0;
  logic [1:0] sel = '0;
  logic       last = 1'b0;
  logic [3:0] rdy = 4'hF;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_stream_1ton_if #(.DATA_W(8), .NUM_CH(4), .CNT_W(8)) if0 ();
  demux_stream_1ton_if #(.DATA_W(8), .NUM_CH(3), .CNT_W(8)) if1 ();
  demux_stream_1ton_if #(.DATA_W(8), .NUM_CH(3), .CNT_W(2)) if2 ();

  demux_stream_1ton #(.DATA_W(8), .NUM_CH(4), .CNT_W(8)) u0 (.clk_in(clk), .rst_in(rst), .bus(if0));
  demux_stream_1ton #(.DATA_W(8), .NUM_CH(3), .CNT_W(8)) u1 (.clk_in(clk), .rst_in(rst), .bus(if1));
  demux_stream_1ton #(.DATA_W(8), .NUM_CH(3), .CNT_W(2)) u2 (.clk_in(clk), .rst_in(rst), .bus(if2));

  assign if0.d_in = d;  assign if0.sel_in = sel; assign if0.valid_in = v;
  assign if0.last_in = last; assign if0.ready_in = rdy;
  assign if1.d_in = d;  assign if1.sel_in = sel; assign if1.valid_in = v;
  assign if1.last_in = last; assign if1.ready_in = rdy[2:0];
  assign if2.d_in = d;  assign if2.sel_in = sel; assign if2.valid_in = v;
  assign if2.last_in = last; assign if2.ready_in = rdy[2:0];

  logic [31:0] yo [3];
  logic [3:0]  vo [3];
  logic [3:0]  lo [3];
  logic [7:0]  dc [3];
  logic        ro [3];

  assign yo[0] = if0.y_out;          assign yo[1] = {8'h0, if1.y_out};  assign yo[2] = {8'h0, if2.y_out};
  assign vo[0] = if0.valid_out;      assign vo[1] = {1'b0, if1.valid_out}; assign vo[2] = {1'b0, if2.valid_out};
  assign lo[0] = if0.last_out;       assign lo[1] = {1'b0, if1.last_out};  assign lo[2] = {1'b0, if2.last_out};
  assign dc[0] = if0.drop_cnt_out;   assign dc[1] = if1.drop_cnt_out;   assign dc[2] = {6'h0, if2.drop_cnt_out};
  assign ro[0] = if0.ready_out;      assign ro[1] = if1.ready_out;      assign ro[2] = if2.ready_out;

  // Packet-level model: mode 0 = between packets, 1 = inside a routed packet,
  // 2 = inside a discarded packet; each channel holds at most one beat.
  typedef struct {
    int         mode;
    int         lock;
    bit [3:0]   v;
    bit [3:0]   l;
    logic [7:0] dat [4];
    int         drop;
  } mdl_t;

  mdl_t m [3];
  int   nch [3];
  int   cmx [3];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit mready(input mdl_t s, input int sl, input bit [3:0] r, input int n);
    int t;
    if (s.mode == 2) return 1'b1;
    if (s.mode == 0 && sl >= n) return 1'b1;
    t = (s.mode == 1) ? s.lock : sl;
    return !s.v[t] || r[t];
  endfunction

  function automatic mdl_t mstep(input mdl_t s, input bit r, input bit vv, input logic [7:0] dd,
                                 input int sl, input bit ll, input bit [3:0] rr, input int n, input int cm);
    mdl_t o;
    bit   a;
    int   t;
    o = s;
    if (r) begin
      o.mode = 0; o.lock = 0; o.v = '0; o.l = '0; o.drop = 0;
      for (int k = 0; k < 4; k++) o.dat[k] = '0;
      return o;
    end
    a = vv && mready(s, sl, rr, n);
    for (int k = 0; k < n; k++) if (s.v[k] && rr[k]) o.v[k] = 1'b0;
    if (a) begin
      t = -1;
      if (s.mode == 2 || (s.mode == 0 && sl >= n)) begin
        if (o.drop < cm) o.drop++;
        o.mode = (s.mode == 0 && !ll) ? 2 : (ll ? 0 : s.mode);
      end else if (s.mode == 0) begin
        t = sl;
        if (!ll) begin o.mode = 1; o.lock = sl; end
      end else begin
        t = s.lock;
        if (ll) o.mode = 0;
      end
      if (t >= 0) begin o.v[t] = 1'b1; o.l[t] = ll; o.dat[t] = dd; end
    end
    return o;
  endfunction

  task automatic compare(input int i);
    logic [31:0] ey;
    logic [3:0]  el;
    ey = '0; el = '0;
    for (int k = 0; k < nch[i]; k++) if (m[i].v[k]) begin
      ey[k*8 +: 8] = m[i].dat[k];
      el[k]        = m[i].l[k];
    end
    chk($sformatf("rdy%0d", i), 32'(ro[i]), rst ? 32'd0 : 32'(mready(m[i], int'(sel), rdy, nch[i])));
    chk($sformatf("vld%0d", i), 32'(vo[i]), 32'(m[i].v));
    chk($sformatf("last%0d", i), 32'(lo[i]), 32'(el));
    chk($sformatf("y%0d", i), yo[i], ey);
    chk($sformatf("drop%0d", i), 32'(dc[i]), 32'(m[i].drop));
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      compare(i);
      m[i] = mstep(m[i], rst, v, d, int'(sel), last, rdy, nch[i], cmx[i]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit vv, input logic [7:0] dd, input int ss, input bit ll, input logic [3:0] rr);
    v = vv; d = dd; sel = 2'(ss); last = ll; rdy = rr;
    tick();
  endtask

  task automatic rst_pulse();
    rst = 1'b1; v = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    nch = '{4, 3, 3};
    cmx = '{255, 255, 3};
    for (int i = 0; i < 3; i++) m[i] = mstep(m[i], 1'b1, 1'b0, '0, 0, 1'b0, '0, nch[i], cmx[i]);
    @(posedge clk); #1;
    rst_pulse();
    chk("rst_vld", 32'(vo[0]), 32'd0);
    chk("rst_drop", 32'(dc[0]), 32'd0);

    // two-beat packet to channel 2, one-cycle latency
    beat(1, 8'hA1, 2, 0, 4'hF);
    chk("p37_b1", 32'(yo[0][23:16]), 32'hA1);
    chk("p37_v1", 32'(vo[0]), 32'b0100);
    beat(1, 8'hA2, 2, 1, 4'hF);
    chk("p37_b2", 32'(yo[0][23:16]), 32'hA2);
    chk("p37_l2", 32'(lo[0]), 32'b0100);
    beat(0, 8'h00, 0, 0, 4'hF);
    chk("p37_end", 32'(vo[0]), 32'd0);

    // select changes after the first beat are ignored
    beat(1, 8'hB1, 1, 0, 4'hF);
    for (int b = 2; b <= 4; b++) begin
      beat(1, 8'(8'hB0 + b), 3, (b == 4), 4'hF);
      chk("p38_ch1", 32'(vo[0]), 32'b0010);
      chk("p38_dat", 32'(yo[0][15:8]), 32'(8'hB0 + b));
    end
    beat(0, 8'h00, 0, 0, 4'hF);

    // downstream stall on channel 0
    rst_pulse();
    beat(1, 8'hC1, 0, 0, 4'hE);
    for (int s = 0; s < 3; s++) begin
      beat(1, 8'hC2, 0, 1, 4'hE);
      chk("p39_hold", 32'(yo[0][7:0]), 32'hC1);
    end
    beat(1, 8'hC2, 0, 1, 4'hF);
    chk("p39_b2", 32'(yo[0][7:0]), 32'hC2);
    chk("p39_l2", 32'(lo[0]), 32'b0001);
    beat(0, 8'h00, 0, 0, 4'hF);
    chk("p39_end", 32'(vo[0]), 32'd0);

    // discarded packet on the 3-channel instances
    rst_pulse();
    for (int b = 0; b < 5; b++) beat(1, 8'(8'hD0 + b), 3, (b == 4), 4'hF);
    chk("p40_drop", 32'(dc[1]), 32'd5);
    chk("p40_novld", 32'(vo[1]), 32'd0);
    beat(1, 8'hD9, 0, 1, 4'hF);
    chk("p40_next", 32'(yo[1][7:0]), 32'hD9);
    chk("p40_nv", 32'(vo[1]), 32'b0001);

    // counter saturation at 2 bits
    rst_pulse();
    for (int b = 0; b < 6; b++) beat(1, 8'(b), 3, 1, 4'hF);
    chk("p41_sat", 32'(dc[2]), 32'd3);
    chk("p41_wide", 32'(dc[1]), 32'd6);

    // reset mid-packet with a stalled channel
    rst_pulse();
    beat(1, 8'hE1, 1, 0, 4'hD);
    beat(1, 8'hE2, 1, 0, 4'hD);
    rst = 1'b1; v = 1'b1;
    tick();
    rst = 1'b0;
    chk("p42_vld", 32'(vo[0]), 32'd0);
    chk("p42_drop", 32'(dc[0]), 32'd0);
    beat(1, 8'hE9, 0, 1, 4'hF);
    chk("p42_new", 32'(yo[0][7:0]), 32'hE9);
    chk("p42_nv", 32'(vo[0]), 32'b0001);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(299) == 0);
      v    = ($urandom_range(3) != 0);
      d    = 8'($urandom);
      sel  = 2'($urandom);
      last = ($urandom_range(3) == 0);
      rdy  = 4'($urandom) | ((c % 50 < 25) ? 4'hA : 4'h0);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_stream_1ton.md
DEMUX_STREAM_1TON -- requirements
Module: demux_stream_1ton

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits, SHALL be >= 1.
REQ-002 Parameter NUM_CH, default 4, output channel count, SHALL be 2..16.
REQ-003 Parameter CNT_W, default 8, drop counter width.
REQ-004 Derived constant SEL_W = max(1, clog2(NUM_CH)); not user-overridable.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk_in  input  1  clock; all state updates on rising edge.
REQ-007 rst_in  input  1  synchronous active-high reset.
REQ-008 d_in  input  DATA_W  upstream payload.
REQ-009 sel_in  input  SEL_W  destination channel; sampled on first beat of packet only.
REQ-010 valid_in  input  1  upstream beat valid.
REQ-011 last_in  input  1  final beat of packet.
REQ-012 ready_out  output  1  upstream may transfer; beat accepted when valid_in & ready_out.
REQ-013 y_out  output  NUM_CH*DATA_W  channel k payload at bits [k*DATA_W +: DATA_W].
REQ-014 valid_out  output  NUM_CH  per-channel beat valid.
REQ-015 last_out  output  NUM_CH  per-channel last flag.
REQ-016 ready_in  input  NUM_CH  per-channel downstream ready; channel k beat consumed when valid_out[k] & ready_in[k].
REQ-017 drop_cnt_out  output  CNT_W  count of discarded beats, saturating.

Function
REQ-018 Each channel SHALL own a one-entry output register (data, last, valid); latency input-accept to valid_out = 1 cycle.
REQ-019 Target channel t SHALL be sel_in in IDLE, the locked channel in ROUTE.
REQ-020 ready_out SHALL be 1 in DROP; 1 in IDLE when sel_in >= NUM_CH; otherwise valid_out[t]==0 | ready_in[t] (combinational, no bubble: one beat/cycle sustained).
REQ-021 A consumed channel register not refilled the same cycle SHALL clear valid_out[k]; simultaneous consume and refill SHALL load the new beat with valid held 1.
REQ-022 While valid_out[k]=1 & ready_in[k]=0, y_out/last_out for channel k SHALL hold stable.
REQ-023 Channels with valid_out[k]=0 SHALL drive y_out slice and last_out[k] to 0.
REQ-024 FSM states IDLE, ROUTE, DROP; IDLE on reset.
REQ-025 IDLE, accepted beat, sel_in < NUM_CH, last_in=0 -> ROUTE, lock sel_in; last_in=1 -> stay IDLE (single-beat packet).
REQ-026 IDLE, accepted beat, sel_in >= NUM_CH -> beat discarded; last_in=0 -> DROP, last_in=1 -> stay IDLE.
REQ-027 ROUTE: sel_in ignored; accepted beat with last_in=1 -> IDLE.
REQ-028 DROP: every accepted beat discarded; accepted last_in=1 -> IDLE.
REQ-029 drop_cnt_out SHALL increment by 1 per discarded beat and saturate at 2^CNT_W-1.
REQ-030 valid_in=0 SHALL cause no state, counter or register change other than downstream consumption.
REQ-031 Only channel t may be written in a cycle; other channels continue draining independently.

Reset
REQ-032 rst_in=1 at a rising edge SHALL force state IDLE, valid_out=0, last_out=0, y_out=0, drop_cnt_out=0, locked channel=0.
REQ-033 Reset mid-packet SHALL abandon the packet and discard any buffered beats; no partial packet emitted after reset.
REQ-034 ready_out SHALL be 0 while rst_in=1.

Structure
REQ-035 State encoding enum and SEL_W derivation function SHALL live in shared package demux_pkg.
REQ-036 One sub-module demux_out_slot (per-channel data/last/valid register with load/consume) SHALL be instantiated NUM_CH times via generate.

Verification
REQ-037 NUM_CH=4, all ready_in=1, packet sel=2 beats 0xA1,0xA2(last) -> channel 2 outputs 0xA1 then 0xA2 with last_out[2]=1, 1-cycle latency, other channels valid 0, y_out slices 0.
REQ-038 Packet sel=1 four beats, sel_in changed to 3 on beats 2..4 -> all four beats on channel 1.
REQ-039 ready_in[0]=0 for 3 cycles with 2-beat packet to channel 0 -> first beat held stable, ready_out=0, second beat delivered after release, no loss or duplication.
REQ-040 NUM_CH=3, packet sel=3 of 5 beats -> no valid_out, drop_cnt_out=5, FSM returns IDLE; next packet sel=0 delivered normally.
REQ-041 CNT_W=2, 6 dropped single-beat packets -> drop_cnt_out saturates at 3.
REQ-042 rst_in pulsed mid-packet with channel 1 stalled holding data -> next cycle valid_out=0, drop_cnt_out=0, new packet sel=0 routed correctly.
